alu_lockstep_monitor: RTL and testbench
=======================================

// Module: alu_lockstep_monitor
// PURPOSE
//   Cycle-by-cycle lockstep checker for a reference ALU and a suspect ALU driven with the same operands.
//   Counts checked vectors and mismatches, captures the first mismatching vector and its XOR bit-mask,
//   accumulates every flipped bit, and raises a sticky alarm at a programmable mismatch threshold.
//   Sits beside the clean/suspect ALU pair in the Trojan analyzer. Feeds logs and side-channel correlation.
// PARAMETERS
//   WIDTH   4   operand/result width in bits
//   OPW     2   opcode width in bits
//   CNT_W   16  width of the vector and mismatch counters (both saturating)
//   THRESH  1   mismatch count at which alarm asserts (1..2**CNT_W-1)
// PORTS
//   clk          in   1      single clock, rising edge
//   rst_n        in   1      synchronous reset, active low
//   in_valid     in   1      sample qualifier: operands and both results are valid this cycle
//   in_a         in   WIDTH  operand A applied to both ALUs
//   in_b         in   WIDTH  operand B applied to both ALUs
//   in_op        in   OPW    opcode applied to both ALUs
//   y_ref        in   WIDTH  clean ALU result
//   y_dut        in   WIDTH  suspect ALU result
//   clr          in   1      synchronous clear of counters, capture, accumulator, alarm, FSM
//   vec_count    out  CNT_W  number of valid samples checked
//   mism_count   out  CNT_W  number of valid samples with y_ref != y_dut
//   cap_valid    out  1      capture registers hold the first mismatch since reset/clr
//   cap_a/cap_b  out  WIDTH  operands of first mismatch
//   cap_op       out  OPW    opcode of first mismatch
//   cap_ref      out  WIDTH  y_ref of first mismatch
//   cap_diff     out  WIDTH  y_ref ^ y_dut of first mismatch
//   diff_acc     out  WIDTH  OR of y_ref ^ y_dut over all valid samples
//   alarm        out  1      sticky: mism_count >= THRESH
//   state        out  2      FSM state (debug)
// BEHAVIOUR
//   - Reset (rst_n=0 at posedge): all outputs 0, state=ARMED. clr=1 has the same effect. rst_n has priority over clr.
//   - clr with in_valid in the same cycle: clr wins. The sample is dropped, not counted, not captured.
//   - Sample accepted on a posedge with in_valid=1. mism = (y_ref !== y_dut). X/Z on either result counts as a mismatch.
//   - Latency 1 cycle: counters, capture, diff_acc, alarm and state reflect sample N after the posedge that accepted N.
//   - vec_count += 1 per accepted sample. mism_count += mism. Both saturate at 2**CNT_W-1 and never wrap.
//   - diff_acc <= diff_acc | (y_ref ^ y_dut) on every accepted sample.
//   - in_valid=0: every register holds.
//   - FSM (encodings in package):
//       ARMED    : mism -> load cap_*, cap_valid=1. Go to ALARM if next mism_count >= THRESH, else CAPTURED.
//       CAPTURED : capture frozen. Go to ALARM when next mism_count >= THRESH.
//       ALARM    : alarm=1, capture frozen. Leave only via reset/clr.
//   - THRESH=1: the first mismatch goes ARMED->ALARM directly, and alarm rises in the same cycle as cap_valid.
//   - Saturated mism_count keeps alarm asserted. alarm is combinational from state==ALARM (no glitch, registered state).
// STRUCTURE
//   - alu_mon_pkg: state typedef/localparams ST_ARMED=2'd0, ST_CAPTURED=2'd1, ST_ALARM=2'd2.
//     Also holds the CNT_MAX helper function.
//   - Sub-module sat_counter #(CNT_W) (en, inc, clr -> q), instantiated twice (vec, mism).
//   - Rest: one FSM always block and one capture/accumulate always block. No latches; all registers rst_n-synchronous.
// TESTING
//   1. Exhaustive 1024 vectors (A,B,op nested). Suspect flips bit0 only at A=F,B=F,op=0, THRESH=1
//      -> vec_count=1024, mism_count=1, cap_a=F, cap_b=F, cap_op=0, cap_diff=0001, diff_acc=0001, alarm=1.
//   2. Identical ALUs, 1024 random vectors, seed FACEB00C
//      -> mism_count=0, cap_valid=0, alarm=0, state=ARMED, vec_count=1024.
//   3. THRESH=3. Mismatches on samples 5, 9, 20 (diffs 0001, 1000, 0001)
//      -> capture = sample 5. After 9: state=CAPTURED, alarm=0. Alarm rises the cycle after 20. diff_acc=1001.
//   4. CNT_W=4. 20 valid samples, all mismatching -> vec_count=mism_count=15 (saturated), alarm held.
//   5. clr asserted with in_valid and a mismatching sample -> next cycle all outputs 0, state=ARMED, sample ignored.
//   6. rst_n pulled low mid-run for one cycle, in_valid=1 -> all outputs 0 next cycle. Counting resumes on the following sample.

Source files
------------

// File: rtl/alu_mon_pkg.sv
// Shared definitions for the ALU lockstep monitor: FSM encoding and the
// saturation limit helper used by the counters.
package alu_mon_pkg;

    typedef enum logic [1:0] {
        ST_ARMED    = 2'd0,
        ST_CAPTURED = 2'd1,
        ST_ALARM    = 2'd2
    } state_e;

    // Largest value representable in a w-bit unsigned counter.
    function automatic logic [31:0] cnt_max(input int w);
        if (w >= 32) begin
            cnt_max = 32'hFFFF_FFFF;
        end else begin
            cnt_max = (32'd1 << w) - 32'd1;
        end
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: adds inc when en is high, sticks at its maximum,
// and exposes its next value so the owner can act on it in the same cycle.
module sat_counter
    import alu_mon_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] q,
    output logic [CNT_W-1:0] nxt
);

    localparam logic [CNT_W-1:0] MAX = CNT_W'(cnt_max(CNT_W));

    logic [CNT_W-1:0] q_q;
    logic [CNT_W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (en && inc && (q_q != MAX)) begin
            q_d = q_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q   = q_q;
    assign nxt = q_d;

endmodule

// File: rtl/alu_lockstep_monitor.sv
// Lockstep checker comparing a clean and a suspect ALU result every valid cycle;
// counts, captures the first mismatch, accumulates flipped bits, raises a sticky alarm.
module alu_lockstep_monitor
    import alu_mon_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int OPW    = 2,
    parameter int CNT_W  = 16,
    parameter int THRESH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [OPW-1:0]   in_op,
    input  logic [WIDTH-1:0] y_ref,
    input  logic [WIDTH-1:0] y_dut,
    input  logic             clr,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] mism_count,
    output logic             cap_valid,
    output logic [WIDTH-1:0] cap_a,
    output logic [WIDTH-1:0] cap_b,
    output logic [OPW-1:0]   cap_op,
    output logic [WIDTH-1:0] cap_ref,
    output logic [WIDTH-1:0] cap_diff,
    output logic [WIDTH-1:0] diff_acc,
    output logic             alarm,
    output logic [1:0]       state
);

    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

    logic             accept;
    logic             mism;
    logic [WIDTH-1:0] diff;
    logic [CNT_W-1:0] vec_nxt;
    logic [CNT_W-1:0] mism_nxt;
    logic             hit_thresh;

    state_e           state_q;
    logic             cap_valid_q;
    logic [WIDTH-1:0] cap_a_q;
    logic [WIDTH-1:0] cap_b_q;
    logic [OPW-1:0]   cap_op_q;
    logic [WIDTH-1:0] cap_ref_q;
    logic [WIDTH-1:0] cap_diff_q;
    logic [WIDTH-1:0] diff_acc_q;

    // clr wins over a coincident sample, so the sample is never accepted.
    // Case inequality makes X/Z on either result count as a mismatch.
    assign accept     = in_valid && !clr;
    assign mism       = (y_ref !== y_dut);
    assign diff       = y_ref ^ y_dut;
    assign hit_thresh = (mism_nxt >= THRESH_C);

    sat_counter #(.CNT_W(CNT_W)) u_vec_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (accept),
        .inc   (1'b1),
        .clr   (clr),
        .q     (vec_count),
        .nxt   (vec_nxt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_mism_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (accept),
        .inc   (mism),
        .clr   (clr),
        .q     (mism_count),
        .nxt   (mism_nxt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            state_q <= ST_ARMED;
        end else if (accept) begin
            case (state_q)
                ST_ARMED: begin
                    if (mism) begin
                        state_q <= hit_thresh ? ST_ALARM : ST_CAPTURED;
                    end
                end
                ST_CAPTURED: begin
                    if (hit_thresh) begin
                        state_q <= ST_ALARM;
                    end
                end
                ST_ALARM: state_q <= ST_ALARM;
                default:  state_q <= ST_ARMED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cap_valid_q <= 1'b0;
            cap_a_q     <= '0;
            cap_b_q     <= '0;
            cap_op_q    <= '0;
            cap_ref_q   <= '0;
            cap_diff_q  <= '0;
            diff_acc_q  <= '0;
        end else if (accept) begin
            diff_acc_q <= diff_acc_q | diff;
            // Only the first mismatch since reset/clr is kept.
            if (mism && (state_q == ST_ARMED)) begin
                cap_valid_q <= 1'b1;
                cap_a_q     <= in_a;
                cap_b_q     <= in_b;
                cap_op_q    <= in_op;
                cap_ref_q   <= y_ref;
                cap_diff_q  <= diff;
            end
        end
    end

    assign cap_valid = cap_valid_q;
    assign cap_a     = cap_a_q;
    assign cap_b     = cap_b_q;
    assign cap_op    = cap_op_q;
    assign cap_ref   = cap_ref_q;
    assign cap_diff  = cap_diff_q;
    assign diff_acc  = diff_acc_q;
    assign alarm     = (state_q == ST_ALARM);
    assign state     = state_q;

endmodule

// File: tb/tb_alu_lockstep_monitor.sv
// Directed bench for the lockstep monitor: three instances cover THRESH=1,
// THRESH=3 and a 4-bit saturating counter configuration on shared stimulus.
module tb_alu_lockstep_monitor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic [1:0] in_op;
    logic [3:0] y_ref;
    logic [3:0] y_dut;
    logic       clr;

    logic [15:0] vc1, mc1;
    logic        cv1, al1;
    logic [3:0]  ca1, cb1, cr1, cd1, da1;
    logic [1:0]  co1, st1;

    logic [15:0] vc3, mc3;
    logic        cv3, al3;
    logic [3:0]  ca3, cb3, cr3, cd3, da3;
    logic [1:0]  co3, st3;

    logic [3:0]  vc4, mc4;
    logic        cv4, al4;
    logic [3:0]  ca4, cb4, cr4, cd4, da4;
    logic [1:0]  co4, st4;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    alu_lockstep_monitor #(.WIDTH(4), .OPW(2), .CNT_W(16), .THRESH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
        .in_op(in_op), .y_ref(y_ref), .y_dut(y_dut), .clr(clr),
        .vec_count(vc1), .mism_count(mc1), .cap_valid(cv1), .cap_a(ca1), .cap_b(cb1),
        .cap_op(co1), .cap_ref(cr1), .cap_diff(cd1), .diff_acc(da1), .alarm(al1), .state(st1)
    );

    alu_lockstep_monitor #(.WIDTH(4), .OPW(2), .CNT_W(16), .THRESH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
        .in_op(in_op), .y_ref(y_ref), .y_dut(y_dut), .clr(clr),
        .vec_count(vc3), .mism_count(mc3), .cap_valid(cv3), .cap_a(ca3), .cap_b(cb3),
        .cap_op(co3), .cap_ref(cr3), .cap_diff(cd3), .diff_acc(da3), .alarm(al3), .state(st3)
    );

    alu_lockstep_monitor #(.WIDTH(4), .OPW(2), .CNT_W(4), .THRESH(1)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
        .in_op(in_op), .y_ref(y_ref), .y_dut(y_dut), .clr(clr),
        .vec_count(vc4), .mism_count(mc4), .cap_valid(cv4), .cap_a(ca4), .cap_b(cb4),
        .cap_op(co4), .cap_ref(cr4), .cap_diff(cd4), .diff_acc(da4), .alarm(al4), .state(st4)
    );

    // Clean ALU behaviour: add, sub, and, xor.
    function automatic logic [3:0] alu(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        case (op)
            2'd0:    alu = a + b;
            2'd1:    alu = a - b;
            2'd2:    alu = a & b;
            default: alu = a ^ b;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clock with the given sample; the suspect result is the clean one XOR fault.
    task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] op, input logic [3:0] fault);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        y_ref    = alu(a, b, op);
        y_dut    = alu(a, b, op) ^ fault;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        drive(1'b0, 4'h0, 4'h0, 2'd0, 4'h0);
        clr = 1'b0;
    endtask

    task automatic chk_zero1(input string tag);
        chk({tag, "_vec"},   32'(vc1), 32'h0);
        chk({tag, "_mism"},  32'(mc1), 32'h0);
        chk({tag, "_capv"},  32'(cv1), 32'h0);
        chk({tag, "_capa"},  32'(ca1), 32'h0);
        chk({tag, "_capd"},  32'(cd1), 32'h0);
        chk({tag, "_acc"},   32'(da1), 32'h0);
        chk({tag, "_alarm"}, 32'(al1), 32'h0);
        chk({tag, "_state"}, 32'(st1), 32'h0);
    endtask

    initial begin
        logic [3:0] fault;
        rst_n    = 1'b0;
        clr      = 1'b0;
        in_valid = 1'b0;
        in_a = '0; in_b = '0; in_op = '0; y_ref = '0; y_dut = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero1("reset");
        rst_n = 1'b1;

        // Exhaustive sweep, single fault at A=F,B=F,op=0 (ref 0xE).
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int op = 0; op < 4; op++) begin
                    fault = (a == 15 && b == 15 && op == 0) ? 4'h1 : 4'h0;
                    drive(1'b1, 4'(a), 4'(b), 2'(op), fault);
                end
            end
        end
        chk("ex_vec",   32'(vc1), 32'd1024);
        chk("ex_mism",  32'(mc1), 32'd1);
        chk("ex_capv",  32'(cv1), 32'd1);
        chk("ex_capa",  32'(ca1), 32'hF);
        chk("ex_capb",  32'(cb1), 32'hF);
        chk("ex_capop", 32'(co1), 32'h0);
        chk("ex_capref",32'(cr1), 32'hE);
        chk("ex_capd",  32'(cd1), 32'h1);
        chk("ex_acc",   32'(da1), 32'h1);
        chk("ex_alarm", 32'(al1), 32'h1);
        chk("ex_state", 32'(st1), 32'h2);

        // Identical ALUs, random operands.
        pulse_clr();
        void'($urandom(32'hFACEB00C));
        for (int i = 0; i < 1024; i++) begin
            drive(1'b1, 4'($urandom_range(15)), 4'($urandom_range(15)), 2'($urandom_range(3)), 4'h0);
        end
        chk("rnd_vec",   32'(vc1), 32'd1024);
        chk("rnd_mism",  32'(mc1), 32'd0);
        chk("rnd_capv",  32'(cv1), 32'd0);
        chk("rnd_alarm", 32'(al1), 32'd0);
        chk("rnd_state", 32'(st1), 32'd0);

        // THRESH=3 with mismatches on samples 5, 9, 20; sample 5 is 5-A=B.
        pulse_clr();
        for (int i = 1; i <= 20; i++) begin
            fault = (i == 5) ? 4'h1 : (i == 9) ? 4'h8 : (i == 20) ? 4'h1 : 4'h0;
            drive(1'b1, 4'(i), 4'(15 - (i % 16)), 2'(i % 4), fault);
            if (i == 5) begin
                chk("t3_s5_capv",  32'(cv3), 32'h1);
                chk("t3_s5_state", 32'(st3), 32'h1);
                chk("t3_s5_alarm", 32'(al3), 32'h0);
            end
            if (i == 9) begin
                chk("t3_s9_state", 32'(st3), 32'h1);
                chk("t3_s9_alarm", 32'(al3), 32'h0);
                chk("t3_s9_mism",  32'(mc3), 32'h2);
            end
            if (i == 19) chk("t3_s19_alarm", 32'(al3), 32'h0);
        end
        chk("t3_alarm", 32'(al3), 32'h1);
        chk("t3_state", 32'(st3), 32'h2);
        chk("t3_acc",   32'(da3), 32'h9);
        chk("t3_capa",  32'(ca3), 32'h5);
        chk("t3_capb",  32'(cb3), 32'hA);
        chk("t3_capop", 32'(co3), 32'h1);
        chk("t3_capref",32'(cr3), 32'hB);
        chk("t3_capd",  32'(cd3), 32'h1);
        chk("t3_vec",   32'(vc3), 32'd20);
        chk("t3_mism",  32'(mc3), 32'd3);

        // 4-bit counters saturate at 15.
        pulse_clr();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 4'(i), 4'h3, 2'd2, 4'h3);
        end
        chk("sat_vec",   32'(vc4), 32'd15);
        chk("sat_mism",  32'(mc4), 32'd15);
        chk("sat_alarm", 32'(al4), 32'd1);
        chk("sat_state", 32'(st4), 32'd2);

        // clr beats a coincident mismatching sample.
        clr = 1'b1;
        drive(1'b1, 4'h7, 4'h2, 2'd0, 4'h4);
        clr = 1'b0;
        chk_zero1("clr");

        // X on the suspect result counts as a mismatch.
        in_valid = 1'b1;
        in_a = 4'h1; in_b = 4'h1; in_op = 2'd0;
        y_ref = 4'h2;
        y_dut = 4'bxxxx;
        @(posedge clk);
        #1;
        chk("x_mism",  32'(mc1), 32'd1);
        chk("x_state", 32'(st1), 32'd2);
        pulse_clr();

        // Reset mid-run with a valid mismatching sample.
        drive(1'b1, 4'h3, 4'h4, 2'd0, 4'h0);
        drive(1'b1, 4'h3, 4'h4, 2'd1, 4'h2);
        rst_n = 1'b0;
        drive(1'b1, 4'h9, 4'h1, 2'd3, 4'h1);
        rst_n = 1'b1;
        chk_zero1("rst");
        drive(1'b1, 4'h2, 4'h2, 2'd0, 4'h0);
        chk("rst_resume_vec",  32'(vc1), 32'd1);
        chk("rst_resume_mism", 32'(mc1), 32'd0);
        in_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
